// File: rtl/vedic_mul_seq_ctrl_if.sv
// Operand, core-multiplier and result handshake bundle for vedic_mul_seq_ctrl.
// The slave modport is the sequencer; the master modport is its environment.
interface vedic_mul_seq_ctrl_if #(
    parameter int W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  a;
    logic [2*W-1:0]  b;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [2*W-1:0]  mul_p;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [4*W-1:0]  product;

    modport slave (
        input  in_valid, a, b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, busy, out_valid, product
    );

    modport master (
        output in_valid, a, b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, busy, out_valid, product
    );
endinterface

// File: rtl/vedic_mul_seq_ctrl.sv
// Sequences a 2W x 2W unsigned multiply over four cycles through one shared
// W x W core, accumulating shifted partial products into a 4W result.
module vedic_mul_seq_ctrl #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vedic_mul_seq_ctrl_if.slave   bus
);
    localparam int PW = 2 * W;
    localparam int RW = 4 * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_step;
    logic [RW-1:0]   r_acc;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic [RW-1:0]   r_product;
    logic [W-1:0]    w_mul_a;
    logic [W-1:0]    w_mul_b;
    logic [RW-1:0]   w_partial;
    logic [RW-1:0]   w_sum;

    // Core operands stay at zero outside CALC so the shared core sees no toggling.
    always_comb begin
        w_mul_a   = '0;
        w_mul_b   = '0;
        w_partial = '0;
        if (r_state == S_CALC) begin
            case (r_step)
                2'd0: begin
                    w_mul_a   = r_a[W-1:0];
                    w_mul_b   = r_b[W-1:0];
                    w_partial = {{(RW-PW){1'b0}}, bus.mul_p};
                end
                2'd1: begin
                    w_mul_a   = r_a[PW-1:W];
                    w_mul_b   = r_b[W-1:0];
                    w_partial = {{W{1'b0}}, bus.mul_p, {W{1'b0}}};
                end
                2'd2: begin
                    w_mul_a   = r_a[W-1:0];
                    w_mul_b   = r_b[PW-1:W];
                    w_partial = {{W{1'b0}}, bus.mul_p, {W{1'b0}}};
                end
                default: begin
                    w_mul_a   = r_a[PW-1:W];
                    w_mul_b   = r_b[PW-1:W];
                    w_partial = {bus.mul_p, {PW{1'b0}}};
                end
            endcase
        end
    end

    assign w_sum = r_acc + w_partial;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)   w_next = S_CALC;
            S_CALC:  if (r_step == 2'd3) w_next = S_DONE;
            S_DONE:  if (bus.out_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                S_CALC: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    // The last partial lands directly in the result register.
                    if (r_step == 2'd3) r_product <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_CALC) || (r_state == S_DONE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.mul_a     = w_mul_a;
    assign bus.mul_b     = w_mul_b;
    assign bus.product   = r_product;
endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed and randomized checks of vedic_mul_seq_ctrl against a plain a*b model,
// with the shared W x W core modelled as a combinational multiply.
module tb_vedic_mul_seq_ctrl;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vedic_mul_seq_ctrl_if #(.W(W)) bus ();

    vedic_mul_seq_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mul_p = {4'b0, bus.mul_a} * {4'b0, bus.mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_mul_a"},     64'(bus.mul_a),     64'd0);
        chk({tag, "_mul_b"},     64'(bus.mul_b),     64'd0);
        chk({tag, "_product"},   64'(bus.product),   64'd0);
    endtask

    // One full transaction with exact-latency and per-step core operand checks.
    task automatic do_op(input logic [7:0] opa, input logic [7:0] opb, input int stall);
        logic [15:0] exp;
        logic [3:0]  ea;
        logic [3:0]  eb;
        exp           = 16'(opa) * 16'(opb);
        bus.a         = opa;
        bus.b         = opb;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_mul_a_zero", 64'(bus.mul_a), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        for (int s = 0; s < 4; s++) begin
            ea = (s % 2 == 1) ? opa[7:4] : opa[3:0];
            eb = (s >= 2)     ? opb[7:4] : opb[3:0];
            chk("calc_busy",      64'(bus.busy),      64'd1);
            chk("calc_in_ready",  64'(bus.in_ready),  64'd0);
            chk("calc_out_valid", 64'(bus.out_valid), 64'd0);
            chk("calc_mul_a",     64'(bus.mul_a),     64'(ea));
            chk("calc_mul_b",     64'(bus.mul_b),     64'(eb));
            tick();
        end
        chk("done_out_valid", 64'(bus.out_valid), 64'd1);
        chk("done_product",   64'(bus.product),   64'(exp));
        chk("done_mul_a_zero", 64'(bus.mul_a),    64'd0);
        for (int k = 0; k < stall; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            tick();
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_product",   64'(bus.product),   64'(exp));
            chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_in_ready",  64'(bus.in_ready),  64'd1);
        chk("post_busy",      64'(bus.busy),      64'd0);
        chk("post_product",   64'(bus.product),   64'(exp));
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] e;
        int acc_n;
        int done_n;
        int cyc;

        total         = 0;
        bad           = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("after_reset");

        // Max operands, sink always ready.
        do_op(8'hFF, 8'hFF, 0);
        // Mixed halves, operand order per step.
        do_op(8'h3C, 8'hA5, 0);

        // Back-to-back with in_valid held high.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a         = 8'd12;
        bus.b         = 8'd34;
        tick();
        bus.a = 8'd0;
        bus.b = 8'd200;
        for (int s = 0; s < 4; s++) begin
            chk("b2b_in_ready_calc", 64'(bus.in_ready), 64'd0);
            tick();
        end
        chk("b2b_first_valid",   64'(bus.out_valid), 64'd1);
        chk("b2b_first_product", 64'(bus.product),   64'd408);
        chk("b2b_in_ready_done", 64'(bus.in_ready),  64'd0);
        tick();
        chk("b2b_idle_in_ready", 64'(bus.in_ready),  64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_second_busy", 64'(bus.busy), 64'd1);
        for (int s = 0; s < 4; s++) tick();
        chk("b2b_second_valid",   64'(bus.out_valid), 64'd1);
        chk("b2b_second_product", 64'(bus.product),   64'd0);
        tick();
        tick();
        chk("b2b_no_duplicate", 64'(bus.busy), 64'd0);

        // Sink stall with in_valid pulses ignored.
        do_op(8'd7, 8'd9, 10);

        // Reset at step2 discards the operation.
        bus.a         = 8'h80;
        bus.b         = 8'h80;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("rst_step2_mul_b", 64'(bus.mul_b), 64'd8);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
        do_op(8'd2, 8'd3, 0);

        // Random traffic against a queue of expected products.
        acc_n  = 0;
        done_n = 0;
        cyc    = 0;
        while (done_n < 1000 && cyc < 40000) begin
            bus.in_valid  = (acc_n < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a         = 8'($urandom);
            bus.b         = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.in_valid && bus.in_ready) begin
                e = 16'(bus.a) * 16'(bus.b);
                q.push_back(e);
                acc_n++;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("rand_expected_pending", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rand_product", 64'(bus.product), 64'(e));
                end
                done_n++;
            end
            tick();
            cyc++;
        end
        chk("rand_completed", 64'(done_n), 64'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
